led_shift_driver: RTL and testbench

//  Downstream stage of the bound flasher: takes the 16-bit LED vector and drives an external

---
 rtl/led_shift_driver_pkg.sv | 19 +
 rtl/led_ser_tick.sv | 35 +++
 rtl/led_shift_driver.sv | 125 ++++++++++++
 tb/tb_led_shift_driver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/led_shift_driver_pkg.sv
`default_nettype none
// ============================================================================
// led_shift_driver_pkg : state encoding and default sizes for the LED chain
// Rev 1.0
// ============================================================================
package led_shift_driver_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_CLK_DIV = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LATCH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/led_ser_tick.sv
`default_nettype none
// ============================================================================
// led_ser_tick : per-state cycle divider, pulses tick on the last cycle of a phase
// Rev 1.0
// ============================================================================
module led_ser_tick
  import led_shift_driver_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int            DW   = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] TERM = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  // Saturates at the terminal count so a phase that is held never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (clear)
      div_cnt <= '0;
    else if (div_cnt != TERM)
      div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == TERM);

endmodule
`default_nettype wire

// File: rtl/led_shift_driver.sv
`default_nettype none
// ============================================================================
// led_shift_driver : shifts LED patterns MSB-first into a 595-style chain and latches
// Rev 1.0
// ============================================================================
module led_shift_driver
  import led_shift_driver_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] led_in,
  input  logic             refresh,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_latch,
  output logic             busy,
  output logic             frame_done
);

  localparam int            BW      = $clog2(WIDTH);
  localparam logic [BW-1:0] TOP_BIT = BW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] shadow, shadow_nx;
  logic [BW-1:0]    bit_cnt, bit_cnt_nx;
  logic             refresh_pend, refresh_pend_nx;
  logic             ser_data_nx, ser_clk_nx, ser_latch_nx, busy_nx, frame_done_nx;
  logic             state_chg;
  logic             tick;

  assign state_chg = (state_nx != state);

  led_ser_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_chg),
    .tick  (tick)
  );

  always_comb begin
    state_nx        = state;
    shadow_nx       = shadow;
    bit_cnt_nx      = bit_cnt;
    refresh_pend_nx = refresh_pend | refresh;
    ser_data_nx     = ser_data;
    ser_clk_nx      = ser_clk;
    ser_latch_nx    = ser_latch;
    busy_nx         = busy;
    frame_done_nx   = 1'b0;
    case (state)
      IDLE: begin
        if ((led_in != shadow) || refresh_pend || refresh) begin
          state_nx        = SETUP;
          shadow_nx       = led_in;
          bit_cnt_nx      = TOP_BIT;
          ser_data_nx     = led_in[WIDTH-1];
          busy_nx         = 1'b1;
          refresh_pend_nx = 1'b0;
        end
      end
      SETUP: begin
        if (tick) begin
          ser_clk_nx = 1'b1;
          state_nx   = HIGH;
        end
      end
      HIGH: begin
        // Data moves only on the falling shift-clock edge, giving equal setup and hold.
        if (tick) begin
          ser_clk_nx = 1'b0;
          if (bit_cnt == '0) begin
            ser_latch_nx = 1'b1;
            state_nx     = LATCH;
          end else begin
            bit_cnt_nx  = bit_cnt - 1'b1;
            ser_data_nx = shadow[bit_cnt_nx];
            state_nx    = SETUP;
          end
        end
      end
      LATCH: begin
        if (tick) begin
          ser_latch_nx  = 1'b0;
          busy_nx       = 1'b0;
          frame_done_nx = 1'b1;
          ser_data_nx   = 1'b0;
          state_nx      = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // refresh_pend comes out of reset set so the chain is always initialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadow       <= '0;
      bit_cnt      <= '0;
      refresh_pend <= 1'b1;
      ser_data     <= 1'b0;
      ser_clk      <= 1'b0;
      ser_latch    <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nx;
      shadow       <= shadow_nx;
      bit_cnt      <= bit_cnt_nx;
      refresh_pend <= refresh_pend_nx;
      ser_data     <= ser_data_nx;
      ser_clk      <= ser_clk_nx;
      ser_latch    <= ser_latch_nx;
      busy         <= busy_nx;
      frame_done   <= frame_done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_shift_driver.sv
`default_nettype none
// ============================================================================
// tb_led_shift_driver : directed checks of both the default and a narrow/fast driver
// Rev 1.0
// ============================================================================
module tb_led_shift_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] led_in = 16'h0000;
  logic        refresh = 1'b0;
  logic        ser_data, ser_clk, ser_latch, busy, frame_done;
  logic [7:0]  led_in2 = 8'h00;
  logic        refresh2 = 1'b0;
  logic        sd2, sc2, sl2, busy2, fd2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  led_shift_driver #(.WIDTH(16), .CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .refresh(refresh),
    .ser_data(ser_data), .ser_clk(ser_clk), .ser_latch(ser_latch),
    .busy(busy), .frame_done(frame_done)
  );

  led_shift_driver #(.WIDTH(8), .CLK_DIV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .led_in(led_in2), .refresh(refresh2),
    .ser_data(sd2), .ser_clk(sc2), .ser_latch(sl2),
    .busy(busy2), .frame_done(fd2)
  );

  // Chain models: shift on sampled sclk rise, capture on latch rise.
  logic [15:0] chain = '0, latched = '0;
  int          sclk_rises = 0, latch_rises = 0, busy_cyc = 0, stab_err = 0;
  logic        p_sc = 0, p_sl = 0, p_sd = 0;
  always @(negedge clk) begin
    if (ser_clk && !p_sc) begin chain = {chain[14:0], ser_data}; sclk_rises++; end
    if (ser_latch && !p_sl) begin latched = chain; latch_rises++; end
    if (ser_clk && (ser_data != p_sd)) stab_err++;
    if (busy) busy_cyc++;
    p_sc = ser_clk; p_sl = ser_latch; p_sd = ser_data;
  end

  logic [7:0] chain2 = '0, latched2 = '0;
  int         sclk2 = 0, latch2 = 0, busy2_cyc = 0, stab_err2 = 0;
  logic       p_sc2 = 0, p_sl2 = 0, p_sd2 = 0;
  always @(negedge clk) begin
    if (sc2 && !p_sc2) begin chain2 = {chain2[6:0], sd2}; sclk2++; end
    if (sl2 && !p_sl2) begin latched2 = chain2; latch2++; end
    if (sc2 && (sd2 != p_sd2)) stab_err2++;
    if (busy2) busy2_cyc++;
    p_sc2 = sc2; p_sl2 = sl2; p_sd2 = sd2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    do begin step(); n++; end while (!busy && n < 400);
    check(tag, busy, 1);
  endtask

  task automatic wait_done(input string tag, output int n);
    n = 0;
    do begin step(); n++; end while (!frame_done && n < 400);
    check(tag, frame_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m, l0, b0, s0, e0, d0, n;
    logic [15:0] pat;

    // Reset state
    repeat (3) step();
    check("reset_outs", {ser_data, ser_clk, ser_latch, busy, frame_done}, 5'b0);

    // Frame of zeros forced by reset
    b0 = busy_cyc; s0 = sclk_rises; l0 = latch_rises;
    rst_n = 1'b1;
    wait_start("t1_start");
    wait_done("t1_done", m);
    check("t1_len", 1 + m, 133);
    check("t1_sclk", sclk_rises - s0, 16);
    check("t1_latch", latch_rises - l0, 1);
    check("t1_busy", busy_cyc - b0, 132);
    check("t1_data", latched, 16'h0000);
    s0 = sclk_rises;
    repeat (40) step();
    check("t1_idle_sclk", sclk_rises - s0, 0);
    check("t1_idle_busy", {busy, frame_done}, 2'b00);

    // 0x001F
    b0 = busy_cyc; s0 = sclk_rises; e0 = stab_err;
    led_in = 16'h001F;
    wait_start("t2_start");
    wait_done("t2_done", m);
    check("t2_len", 1 + m, 133);
    check("t2_data", latched, 16'h001F);
    check("t2_sclk", sclk_rises - s0, 16);
    check("t2_busy", busy_cyc - b0, 132);
    check("t2_stab", stab_err - e0, 0);

    // Changes while busy: only the latest value follows
    l0 = latch_rises;
    led_in = 16'h0001;
    wait_start("t3_start");
    repeat (19) step();
    led_in = 16'h0003;
    repeat (40) step();
    led_in = 16'h0007;
    wait_done("t3_done", m);
    check("t3_len", 60 + m, 133);
    check("t3_first", latched, 16'h0001);
    wait_start("t3_start2");
    wait_done("t3_done2", m);
    check("t3_second", latched, 16'h0007);
    repeat (20) step();
    check("t3_latches", latch_rises - l0, 2);

    // Refresh collapsing
    l0 = latch_rises; d0 = 0;
    refresh = 1'b1;
    step();
    refresh = 1'b0;
    check("t4_start", busy, 1);
    repeat (10) step();
    refresh = 1'b1; step(); refresh = 1'b0;
    repeat (30) step();
    refresh = 1'b1; step(); refresh = 1'b0;
    repeat (30) step();
    refresh = 1'b1; step(); refresh = 1'b0;
    wait_done("t4_doneA", m);
    wait_start("t4_startB");
    wait_done("t4_doneB", m);
    repeat (50) step();
    check("t4_latches", latch_rises - l0, 2);
    check("t4_data", latched, 16'h0007);

    // refresh and a change in the same idle cycle -> one frame
    l0 = latch_rises;
    led_in = 16'h0008; refresh = 1'b1;
    step();
    refresh = 1'b0;
    repeat (300) step();
    check("t4b_latches", latch_rises - l0, 1);
    check("t4b_data", latched, 16'h0008);

    // Async reset mid-frame
    l0 = latch_rises;
    led_in = 16'hFFFF;
    wait_start("t5_start");
    repeat (49) step();
    check("t5_pre", {ser_data, busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check("t5_async", {ser_data, ser_clk, ser_latch, busy, frame_done}, 5'b0);
    repeat (5) step();
    check("t5_nolatch", latch_rises - l0, 0);
    rst_n = 1'b1;
    wait_start("t5_restart");
    wait_done("t5_done", m);
    check("t5_data", latched, 16'hFFFF);
    check("t5_latches", latch_rises - l0, 1);

    // Narrow fast instance: WIDTH=8, CLK_DIV=1
    repeat (30) step();
    b0 = busy2_cyc; s0 = sclk2; e0 = stab_err2;
    led_in2 = 8'hA5;
    n = 0;
    do begin step(); n++; end while (!busy2 && n < 50);
    check("t6_start", busy2, 1);
    pat = '0;
    for (int i = 0; i < 16; i++) begin
      pat[i] = sc2;
      step();
    end
    check("t6_latch_cyc", sl2, 1);
    step();
    check("t6_done_cyc", fd2, 1);
    check("t6_sclk_pat", pat, 16'hAAAA);
    check("t6_sclk", sclk2 - s0, 8);
    check("t6_busy", busy2_cyc - b0, 17);
    check("t6_stab", stab_err2 - e0, 0);
    check("t6_data", latched2, 8'hA5);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
